fir_seq_ctrl: RTL and testbench

Parametrised sequencer that feeds a FIR engine (binary or RNS path) from a loadable sample buffer and captures the filter outputs into a result buffer for register readback. It replaces the fixed 10-sample hard-wired feed loop with a streaming valid/ready interface, run-time sample loading and an optional tail flush. It sits between the host register interface and the FIR core, above the int/RNS converters.

---
 rtl/fir_seq_pkg.sv | 27 ++
 rtl/fir_seq_ram.sv | 42 ++++
 rtl/fir_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR sample/result sequencer.
// Holds the FSM state encoding and the run-length arithmetic used by the top.
package fir_seq_pkg;

   localparam int DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   // Number of results a run expects: one per fed sample, plus the tail
   // produced by the TAP_CNT-1 zero samples when flushing.
   function automatic int calc_target(input int sample_cnt, input int tap_cnt,
                                      input logic flush);
      return flush ? (sample_cnt + tap_cnt - 1) : sample_cnt;
   endfunction

   // Address width that never collapses to zero for a single-entry buffer.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fir_seq_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module fir_seq_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   // Storage is sized to the full address space so every index is legal;
   // entries at or beyond DEPTH are simply never written or returned.
   logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < DEPTH_C)) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if ({1'b0, raddr} < DEPTH_C) begin
         rdata_q <= mem_q[raddr];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer feeding a FIR core from a loadable sample buffer over valid/ready
// and capturing the core's outputs into a result buffer for host readback.
module fir_seq_ctrl
   import fir_seq_pkg::*;
#(
   parameter  int DATA_W     = DEF_DATA_W,
   parameter  int SAMPLE_CNT = 10,
   parameter  int TAP_CNT    = 10,
   localparam int RES_DEPTH  = SAMPLE_CNT + TAP_CNT - 1,
   localparam int AW         = addr_w(RES_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush_en,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] x_data,
   output logic              x_valid,
   input  logic              x_ready,
   input  logic [DATA_W-1:0] y_data,
   input  logic              y_valid,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [AW:0]       res_count
);

   localparam logic [AW-1:0] LAST_IDX = AW'(SAMPLE_CNT - 1);
   localparam logic [AW-1:0] LAST_FL  = AW'((TAP_CNT > 1) ? (TAP_CNT - 2) : 0);
   localparam logic [AW:0]   TGT_FL   = (AW+1)'(calc_target(SAMPLE_CNT, TAP_CNT, 1'b1));
   localparam logic [AW:0]   TGT_NF   = (AW+1)'(calc_target(SAMPLE_CNT, TAP_CNT, 1'b0));
   localparam logic          HAS_TAIL = (TAP_CNT > 1);

   seq_state_t        state_q;
   logic [AW-1:0]     idx_q;
   logic [AW-1:0]     fl_cnt_q;
   logic [AW:0]       res_cnt_q;
   logic              flush_q;
   logic              x_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              ovf_q;

   logic              idle_like;
   logic              xfer;
   logic              cap;
   logic              res_we;
   logic              samp_we;
   logic [AW:0]       target;
   logic [AW-1:0]     samp_raddr;
   logic [DATA_W-1:0] samp_rdata;

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign xfer      = x_valid_q && x_ready;
   assign cap       = y_valid && !idle_like;
   assign target    = flush_q ? TGT_FL : TGT_NF;
   assign res_we    = cap && (res_cnt_q != target);
   assign samp_we   = wr_en && idle_like;

   // Prefetch: the sample RAM has one cycle of read latency, so its address
   // runs one index ahead whenever the current sample is being accepted and
   // stays put while the core stalls, which keeps x_data stable.
   always_comb begin
      samp_raddr = idx_q;
      if (idle_like) begin
         samp_raddr = '0;
      end else if ((state_q == FEED) && xfer) begin
         samp_raddr = idx_q + AW'(1);
      end
   end

   fir_seq_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (SAMPLE_CNT),
      .AW     (AW)
   ) u_samp_ram (
      .clk    (clk),
      .reset  (reset),
      .we     (samp_we),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .raddr  (samp_raddr),
      .rdata  (samp_rdata)
   );

   fir_seq_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (RES_DEPTH),
      .AW     (AW)
   ) u_res_ram (
      .clk    (clk),
      .reset  (reset),
      .we     (res_we),
      .waddr  (res_cnt_q[AW-1:0]),
      .wdata  (y_data),
      .raddr  (rd_addr),
      .rdata  (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         fl_cnt_q  <= '0;
         res_cnt_q <= '0;
         flush_q   <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         // Capture runs independently of the feed side so a sample transfer
         // and a result arriving in the same cycle are both honoured.
         if (cap) begin
            if (res_cnt_q == target) begin
               ovf_q <= 1'b1;
            end else begin
               res_cnt_q <= res_cnt_q + (AW+1)'(1);
            end
         end

         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q   <= FEED;
                  flush_q   <= flush_en;
                  idx_q     <= '0;
                  fl_cnt_q  <= '0;
                  res_cnt_q <= '0;
                  ovf_q     <= 1'b0;
                  done_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  x_valid_q <= 1'b1;
               end
            end
            FEED: begin
               if (xfer) begin
                  if (idx_q == LAST_IDX) begin
                     if (flush_q && HAS_TAIL) begin
                        state_q <= FLUSH;
                     end else begin
                        state_q   <= DRAIN;
                        x_valid_q <= 1'b0;
                     end
                  end else begin
                     idx_q <= idx_q + AW'(1);
                  end
               end
            end
            FLUSH: begin
               if (xfer) begin
                  if (fl_cnt_q == LAST_FL) begin
                     state_q   <= DRAIN;
                     x_valid_q <= 1'b0;
                  end else begin
                     fl_cnt_q <= fl_cnt_q + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (res_cnt_q == target) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               x_valid_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Flush samples are zero; outside FEED the bus is parked at zero.
   assign x_data    = (state_q == FEED) ? samp_rdata : '0;
   assign x_valid   = x_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign res_count = res_cnt_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed plus randomized bench for fir_seq_ctrl with a 3-tap moving-sum core.
module tb_fir_seq_ctrl;

   localparam int DW = 32;
   localparam int SC = 4;
   localparam int TC = 3;
   localparam int RD = SC + TC - 1;
   localparam int AW = $clog2(RD);

   logic          clk;
   logic          reset;
   logic          start;
   logic          flush_en;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] x_data;
   logic          x_valid;
   logic          x_ready;
   logic [DW-1:0] y_data;
   logic          y_valid;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [AW:0]   res_count;

   fir_seq_ctrl #(
      .DATA_W     (DW),
      .SAMPLE_CNT (SC),
      .TAP_CNT    (TC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .flush_en  (flush_en),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .x_data    (x_data),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .y_data    (y_data),
      .y_valid   (y_valid),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .res_count (res_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;
   int cyc  = 0;
   int viol = 0;
   logic [DW-1:0] xq[$];
   int            tq[$];
   logic          mdl_clr = 1'b0;
   logic          dup_en  = 1'b0;

   logic [DW-1:0] smp[SC];
   logic [DW-1:0] seq_e[$];
   logic [DW-1:0] res_e[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Transfer monitor: logs every accepted sample and flags any change of
   // x_valid/x_data while the previous cycle was stalled.
   initial begin
      logic          pstall;
      logic [DW-1:0] pdat;
      pstall = 1'b0;
      pdat   = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset) begin
            if (pstall && !(x_valid === 1'b1 && x_data === pdat)) viol++;
            if (x_valid && x_ready) begin
               xq.push_back(x_data);
               tq.push_back(cyc);
            end
            pstall = x_valid && !x_ready;
            pdat   = x_data;
         end else begin
            pstall = 1'b0;
         end
      end
   end

   // Behavioural FIR core: coefficients 1,1,1, two-cycle latency, optional
   // extra word right after the SC-th result.
   initial begin
      logic          xf;
      logic [DW-1:0] xd, h1, h2, p1d;
      logic          p1v, dupn;
      int            ycnt;
      y_valid = 1'b0;
      y_data  = '0;
      h1 = '0; h2 = '0; p1d = '0; p1v = 1'b0; dupn = 1'b0; ycnt = 0;
      forever begin
         @(posedge clk);
         xf = x_valid && x_ready && !reset;
         xd = x_data;
         if (mdl_clr) begin
            h1 = '0; h2 = '0; p1v = 1'b0; p1d = '0; ycnt = 0; dupn = 1'b0;
         end
         #1;
         if (p1v) begin
            y_valid = 1'b1;
            y_data  = p1d;
            ycnt++;
            if (dup_en && ycnt == SC) dupn = 1'b1;
         end else if (dupn) begin
            y_valid = 1'b1;
            y_data  = 32'hDEAD_BEEF;
            dupn    = 1'b0;
         end else begin
            y_valid = 1'b0;
            y_data  = '0;
         end
         p1v = xf;
         p1d = xd + h1 + h2;
         if (xf) begin
            h2 = h1;
            h1 = xd;
         end
      end
   end

   // Expected stream straight from the run rules: the samples, then TC-1
   // zeros when flushing; each result is the sum of the last TC stream values.
   task automatic build_ref(input bit fl);
      logic [DW-1:0] acc;
      seq_e.delete();
      res_e.delete();
      for (int i = 0; i < SC; i++) seq_e.push_back(smp[i]);
      if (fl) for (int k = 0; k < TC - 1; k++) seq_e.push_back('0);
      for (int i = 0; i < seq_e.size(); i++) begin
         acc = '0;
         for (int j = 0; j < TC; j++) if (i - j >= 0) acc = acc + seq_e[i-j];
         res_e.push_back(acc);
      end
   endtask

   task automatic load();
      for (int i = 0; i < SC; i++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_data = smp[i];
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic run(input bit fl, input int bp, input bit illegal, input bit dup);
      int n;
      int first;
      xq.delete();
      tq.delete();
      viol     = 0;
      mdl_clr  = 1'b1;
      dup_en   = dup;
      flush_en = fl;
      start    = 1'b1;
      step();
      start    = 1'b0;
      flush_en = 1'b0;
      mdl_clr  = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("done_clr_after_start", 32'(done), 32'd0);
      n = 0;
      first = -1;
      while (!done && n < 300) begin
         if (x_valid && first < 0) first = n + 1;
         case (bp)
            0:       x_ready = 1'b1;
            1:       x_ready = (n % 2) == 1;
            default: x_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (illegal && n == 2) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = 32'd99;
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         step();
         n++;
      end
      start   = 1'b0;
      wr_en   = 1'b0;
      x_ready = 1'b1;
      chk("run_timeout", 32'(n < 300), 32'd1);
      chk("xvalid_latency", 32'(first >= 1 && first <= 2), 32'd1);
   endtask

   task automatic verify(input string tag);
      chk({tag, "_xfer_cnt"}, 32'(xq.size()), 32'(seq_e.size()));
      for (int i = 0; i < seq_e.size() && i < xq.size(); i++)
         chk($sformatf("%s_x%0d", tag, i), xq[i], seq_e[i]);
      for (int i = 0; i < res_e.size(); i++) begin
         rd_addr = AW'(i);
         step();
         chk($sformatf("%s_res%0d", tag, i), rd_data, res_e[i]);
      end
      chk({tag, "_res_count"}, 32'(res_count), 32'(res_e.size()));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_stall_hold"}, 32'(viol), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit fl;
      reset    = 1'b1;
      start    = 1'b0;
      flush_en = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
      x_ready  = 1'b1;
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_res_count", 32'(res_count), 32'd0);
      chk("rst_x_valid", 32'(x_valid), 32'd0);
      chk("rst_x_data", x_data, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      reset = 1'b0;
      step();

      smp[0] = 32'd1; smp[1] = 32'd2; smp[2] = 32'd3; smp[3] = 32'd4;
      load();

      // No flush, full-rate handshake
      build_ref(1'b0);
      run(1'b0, 0, 1'b0, 1'b0);
      verify("noflush");
      chk("noflush_overflow", 32'(overflow), 32'd0);
      chk("noflush_back2back", 32'(tq.size() == SC && (tq[SC-1] - tq[0]) == SC - 1), 32'd1);
      chk("noflush_res3_const", res_e[3], 32'd9);

      // Flush tail
      build_ref(1'b1);
      run(1'b1, 0, 1'b0, 1'b0);
      verify("flush");
      rd_addr = AW'(5);
      step();
      chk("flush_rd5", rd_data, 32'd4);
      rd_addr = AW'(6);
      step();
      chk("rd_oob6", rd_data, 32'd0);
      rd_addr = AW'(7);
      step();
      chk("rd_oob7", rd_data, 32'd0);

      // Alternate-cycle backpressure
      build_ref(1'b0);
      run(1'b0, 1, 1'b0, 1'b0);
      verify("bp");

      // start and wr_en while busy are ignored; a second run proves the
      // sample buffer kept its contents
      run(1'b0, 0, 1'b1, 1'b0);
      verify("illegal");
      run(1'b0, 0, 1'b0, 1'b0);
      verify("after_illegal");

      // Extra core word after the buffer is full
      run(1'b0, 0, 1'b0, 1'b1);
      verify("ovf");
      chk("ovf_flag", 32'(overflow), 32'd1);
      dup_en = 1'b0;

      // Reset while feeding index 2
      xq.delete();
      tq.delete();
      mdl_clr = 1'b1;
      start   = 1'b1;
      step();
      start   = 1'b0;
      mdl_clr = 1'b0;
      chk("midrst_ovf_cleared", 32'(overflow), 32'd0);
      n = 0;
      while (xq.size() < 2 && n < 50) begin
         step();
         n++;
      end
      chk("midrst_reach_idx2", 32'(n < 50), 32'd1);
      chk("midrst_x_data_idx2", x_data, smp[2]);
      reset = 1'b1;
      step();
      chk("midrst_x_valid", 32'(x_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      step();
      build_ref(1'b0);
      run(1'b0, 0, 1'b0, 1'b0);
      verify("post_rst");
      chk("post_rst_overflow", 32'(overflow), 32'd0);

      // Randomized samples, flush mode and backpressure
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < SC; i++) smp[i] = $urandom;
         fl = 1'($urandom_range(0, 1));
         load();
         build_ref(fl);
         run(fl, 2, 1'b0, 1'b0);
         verify($sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d_overflow", r), 32'(overflow), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
